// File: rtl/mtm_alu_frame_ctrl_if.sv
// Packet input, result handshake and status signals between the deserializer,
// the frame controller and the ALU core.
interface mtm_alu_frame_ctrl_if;
    logic        pkt_valid;
    logic [9:0]  pkt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        out_err;
    logic [2:0]  out_flags;
    logic        busy;
    logic        overrun;

    // Packet/ready source (deserializer + core side)
    modport master (
        output pkt_valid, pkt, out_ready,
        input  out_valid, out_a, out_b, out_op, out_err, out_flags, busy, overrun
    );

    // Frame controller side
    modport slave (
        input  pkt_valid, pkt, out_ready,
        output out_valid, out_a, out_b, out_op, out_err, out_flags, busy, overrun
    );
endinterface

// File: rtl/mtm_alu_frame_ctrl.sv
// Frame sequencer: gathers 8 data packets and a CMD packet into one operation,
// validates count, CRC-4 and opcode, then offers a command or a one-hot error
// result to the ALU core over a valid/ready handshake.
module mtm_alu_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 rst,
    mtm_alu_frame_ctrl_if.slave bus
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StCheck, StIssue} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [63:0]       shift_q, shift_d;
    logic [2:0]        cmd_op_q, cmd_op_d;
    logic [3:0]        cmd_crc_q, cmd_crc_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_a_q, res_a_d;
    logic [31:0]       res_b_q, res_b_d;
    logic [2:0]        res_op_q, res_op_d;
    logic              res_err_q, res_err_d;
    logic [2:0]        res_flags_q, res_flags_d;
    logic              overrun_q, overrun_d;

    logic       pkt_is_cmd;
    logic [7:0] pkt_byte;
    logic       pkt_stop;
    logic [3:0] crc_calc;
    logic       start_frame;

    // CRC-4, polynomial x^4+x+1, zero init, MSB first
    function automatic logic [3:0] crc4(input logic [67:0] bits);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    assign pkt_is_cmd = bus.pkt[9];
    assign pkt_byte   = bus.pkt[8:1];
    assign pkt_stop   = bus.pkt[0];
    assign crc_calc   = crc4({shift_q, 1'b1, cmd_op_q});

    // Next-state and result computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        cmd_op_d    = cmd_op_q;
        cmd_crc_d   = cmd_crc_q;
        res_valid_d = res_valid_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        res_flags_d = res_flags_q;
        overrun_d   = overrun_q;
        start_frame = 1'b0;

        unique case (state_q)
            StIdle: start_frame = 1'b1;
            StCollect: begin
                if (bus.pkt_valid) begin
                    timer_d = '0;
                    if (!pkt_stop) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else if (pkt_is_cmd) begin
                        cmd_op_d  = pkt_byte[6:4];
                        cmd_crc_d = pkt_byte[3:0];
                        state_d   = StCheck;
                    end else begin
                        shift_d = {shift_q[55:0], pkt_byte};
                        cnt_d   = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
                    end
                end else if (timer_q == TimerMax) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StCheck: begin
                if (bus.pkt_valid) overrun_d = 1'b1;
                res_valid_d = 1'b1;
                res_a_d     = shift_q[31:0];
                res_b_d     = shift_q[63:32];
                res_op_d    = cmd_op_q;
                res_err_d   = 1'b1;
                res_flags_d = 3'b000;
                if (cnt_q != 4'd8)             res_flags_d = 3'b100;
                else if (crc_calc != cmd_crc_q) res_flags_d = 3'b010;
                else if (cmd_op_q[1])           res_flags_d = 3'b001;
                else                            res_err_d   = 1'b0;
                state_d = StIssue;
            end
            StIssue: begin
                if (res_valid_q && bus.out_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                    cnt_d       = 4'd0;
                    start_frame = 1'b1;
                end else if (bus.pkt_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A packet seen in IDLE, or in the handshake cycle, opens a new frame
        if (start_frame && bus.pkt_valid) begin
            if (!pkt_stop) begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end else if (pkt_is_cmd) begin
                cmd_op_d  = pkt_byte[6:4];
                cmd_crc_d = pkt_byte[3:0];
                cnt_d     = 4'd0;
                state_d   = StCheck;
            end else begin
                shift_d = {shift_q[55:0], pkt_byte};
                cnt_d   = 4'd1;
                timer_d = '0;
                state_d = StCollect;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            timer_q     <= '0;
            shift_q     <= 64'd0;
            cmd_op_q    <= 3'd0;
            cmd_crc_q   <= 4'd0;
            res_valid_q <= 1'b0;
            res_a_q     <= 32'd0;
            res_b_q     <= 32'd0;
            res_op_q    <= 3'd0;
            res_err_q   <= 1'b0;
            res_flags_q <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            shift_q     <= shift_d;
            cmd_op_q    <= cmd_op_d;
            cmd_crc_q   <= cmd_crc_d;
            res_valid_q <= res_valid_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            res_flags_q <= res_flags_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = res_valid_q;
    assign bus.out_a     = res_a_q;
    assign bus.out_b     = res_b_q;
    assign bus.out_op    = res_op_q;
    assign bus.out_err   = res_err_q;
    assign bus.out_flags = res_flags_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mtm_alu_frame_ctrl.sv
// Scoreboard bench for the frame controller: stimulus pushes expected results
// from a reference model, a monitor pops them on every handshake.
module tb_mtm_alu_frame_ctrl;

    typedef struct packed {
        logic        err;
        logic [2:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic rand_rdy = 1'b0;

    mtm_alu_frame_ctrl_if bus ();

    mtm_alu_frame_ctrl #(.TIMEOUT_CYCLES(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] mk_pkt(input logic flag, input logic [7:0] b, input logic stop);
        return {flag, b, stop};
    endfunction

    // Remainder of polynomial division by 10011 over message * x^4
    function automatic logic [3:0] ref_crc(input logic [67:0] m);
        logic [71:0] v;
        v = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic logic [7:0] good_cmd(input logic [63:0] ba, input logic [2:0] op);
        return {1'b0, op, ref_crc({ba, 1'b1, op})};
    endfunction

    function automatic exp_t model(input int n, input logic [63:0] ba, input logic [7:0] cmd);
        exp_t e;
        logic [2:0] op;
        op = cmd[6:4];
        e = '0;
        e.err = 1'b1;
        if (n != 8) e.flags = 3'b100;
        else if (cmd[3:0] != ref_crc({ba, 1'b1, op})) e.flags = 3'b010;
        else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) e.flags = 3'b001;
        else begin
            e.err = 1'b0;
            e.a   = ba[31:0];
            e.b   = ba[63:32];
            e.op  = op;
        end
        return e;
    endfunction

    task automatic send_pkt(input logic [9:0] p);
        bus.pkt_valid = 1'b1;
        bus.pkt       = p;
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;
        bus.pkt       = 10'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // n data bytes from {B,A} MSB-first, optional random gaps, then the CMD packet
    task automatic send_frame(input int n, input logic [63:0] ba, input logic [7:0] cmd,
                              input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_pkt(mk_pkt(1'b0, ba[63 - 8 * (i % 8) -: 8], 1'b1));
            if (gaps) idle($urandom_range(0, 3));
        end
        sb.push_back(model(n, ba, cmd));
        send_pkt(mk_pkt(1'b1, cmd, 1'b1));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            @(posedge clk); #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
        check("drain", 96'(sb.size()), 96'd0);
        sb.delete();
        bus.out_ready = 1'b1;
    endtask

    function automatic logic [70:0] cur_payload();
        exp_t c;
        c.err = bus.out_err; c.flags = bus.out_flags;
        c.a = bus.out_a; c.b = bus.out_b; c.op = bus.out_op;
        return c;
    endfunction

    // Monitor: compare on each handshake, and check payload holds while stalled
    initial begin : monitor
        logic        prev_hold;
        logic [70:0] prev_pay;
        exp_t        e, act;
        prev_hold = 1'b0;
        prev_pay  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold)
                    check("hold_stable", {24'd0, bus.out_valid, cur_payload()}, {24'd0, 1'b1, prev_pay});
                if (bus.out_valid && bus.out_ready) begin
                    act = cur_payload();
                    if (sb.size() == 0) begin
                        check("unexpected_result", 96'd1, 96'd0);
                    end else begin
                        e = sb.pop_front();
                        if (e.err) act = {act.err, act.flags, 67'd0};
                        check("result", {25'd0, act}, {25'd0, e});
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_pay  = cur_payload();
            end
        end
    end

    initial begin : stim
        logic [63:0] ba;
        logic [2:0]  op;
        logic [7:0]  cmd;
        int          n;
        bus.pkt_valid = 1'b0;
        bus.pkt       = 10'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.out_valid, bus.out_a, bus.out_b, bus.out_op, bus.out_err,
                                bus.out_flags, bus.busy, bus.overrun}, 96'd0);
        rst = 1'b0;
        idle(2);

        // Good AND frame, A=B=0, CMD 0x0B; latency N+2
        for (int i = 0; i < 8; i++) send_pkt(10'h001);
        sb.push_back(model(8, 64'd0, 8'h0B));
        send_pkt(10'h217);
        check("latency_n1_low", 96'(bus.out_valid), 96'd0);
        idle(1);
        check("latency_n2_high", 96'(bus.out_valid), 96'd1);
        wait_drain(20);

        // Bad CRC
        for (int i = 0; i < 8; i++) send_pkt(10'h001);
        sb.push_back(model(8, 64'd0, 8'h0A));
        send_pkt(10'h215);
        wait_drain(20);

        // Invalid opcode with correct CRC
        send_frame(8, 64'd0, 8'h2D, 1'b0);
        wait_drain(20);

        // Wrong data counts, including a bare CMD
        send_frame(7, 64'd0, 8'h0B, 1'b0);
        wait_drain(20);
        send_frame(9, 64'd0, 8'h0B, 1'b0);
        wait_drain(20);
        send_frame(0, 64'd0, 8'h0B, 1'b0);
        wait_drain(20);

        // Inter-packet timeout
        for (int i = 0; i < 3; i++) send_pkt(10'h001);
        idle(1000);
        check("timeout_not_yet", 96'(bus.busy), 96'd1);
        idle(30);
        check("timeout_busy", 96'(bus.busy), 96'd0);
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b100), 1'b0);
        wait_drain(20);

        // Framing error discards the partial frame
        for (int i = 0; i < 4; i++) send_pkt(10'h001);
        send_pkt(mk_pkt(1'b0, 8'h55, 1'b0));
        check("framing_idle", 96'(bus.busy), 96'd0);
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b101), 1'b0);
        wait_drain(20);

        // Next frame starts in the handshake cycle: accepted, no overrun
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b001), 1'b0);
        idle(1);
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b000), 1'b0);
        wait_drain(20);
        check("no_overrun", 96'(bus.overrun), 96'd0);

        // Stall 50 cycles, packet during the stall is dropped
        bus.out_ready = 1'b0;
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b100), 1'b0);
        idle(20);
        send_pkt(10'h1FF);
        idle(29);
        check("overrun_set", 96'(bus.overrun), 96'd1);
        bus.out_ready = 1'b1;
        wait_drain(20);
        ba = {$urandom, $urandom};
        send_frame(8, ba, good_cmd(ba, 3'b101), 1'b0);
        wait_drain(20);

        // Randomized frames with gaps and random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            ba = {$urandom, $urandom};
            op = 3'($urandom_range(0, 7));
            cmd = good_cmd(ba, op);
            if ($urandom_range(0, 4) == 0) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
            n = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 7 : 9) : 8;
            send_frame(n, ba, cmd, 1'b1);
            wait_drain(200);
        end
        rand_rdy = 1'b0;
        check("overrun_sticky", 96'(bus.overrun), 96'd1);

        // Asynchronous reset mid-COLLECT
        for (int i = 0; i < 3; i++) send_pkt(10'h003);
        rst = 1'b1;
        #1;
        check("async_reset", {bus.out_valid, bus.out_a, bus.out_b, bus.out_op, bus.out_err,
                              bus.out_flags, bus.busy, bus.overrun}, 96'd0);
        idle(2);
        rst = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
